seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Downstream display stage for the nibble register board. It accepts nibble writes (digit index plus 4-bit value) into an internal 8-digit buffer. It time-multiplexes the buffer onto a common-anode 8-digit seven-segment display. Each digit is shown for a programmable number of clock cycles, and a frame strobe marks each complete refresh.

Parameters:
SCAN_DIV, 100000, clk cycles each digit is displayed; legal range 1..2^DIV_W-1.
DIV_W, 17, width of the prescaler counter.

Ports:
clk  in  1  system clock
rst  in  1  reset
wr_en  in  1  write strobe for the digit buffer, sampled on rising clk
wr_idx  in  3  digit index written (0 = rightmost)
wr_data  in  4  hex nibble written
digit_en  in  8  per-digit enable; 0 forces that digit dark
dp_in  in  8  per-digit decimal point request, active-high
seg  out  7  segments, active-low; seg[0]=a … seg[6]=g
dp  out  1  decimal point, active-low
an  out  8  digit anodes, active-low, one-hot or all-high
scan_idx  out  3  digit currently driven
frame_tick  out  1  one-cycle pulse when scan wraps 7->0

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
- Values while rst is high: buf[0..7]=0, prescaler=0, scan_idx=0, seg=7'h7F, dp=1, an=8'hFF, frame_tick=0.
- Release from reset is synchronous to the next rising clk; no output glitch on release.
- Digit buffer: 8x4 registers. When wr_en=1 at a rising edge, buf[wr_idx] <= wr_data. Only one write per cycle, no back-pressure.
- Prescaler: counts 0..SCAN_DIV-1. At terminal count (SCAN_DIV-1) it resets to 0 and scan_idx increments, wrapping 7->0. With SCAN_DIV=1, scan_idx advances every cycle.
- frame_tick: registered. It is 1 for exactly the cycle in which scan_idx has just become 0 from 7; otherwise 0.
- Output stage: seg, dp and an are registered from the current scan_idx, buf[scan_idx], digit_en and dp_in. Latency is 1 clk from any change of scan_idx, buffer or enables to the pins.
- A write to the digit currently being shown appears on seg on the second rising edge after the write edge: buffer update, then output register.
- an: bit scan_idx low, all other bits high. If digit_en[scan_idx]=0, an=8'hFF, seg=7'h7F and dp=1.
- dp = ~dp_in[scan_idx] when the digit is enabled.
- Hex decode, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Simultaneous events: a write and a scan advance on the same edge both take effect. The next output register load uses the new scan_idx and the updated buffer.
- Reset mid-scan: all state returns to reset values immediately, regardless of clk. The buffer contents are lost.
- Prescaler and scan_idx must never hold values outside their ranges. A prescaler value ≥SCAN_DIV is unreachable.

Test Plan:
- Reset check (SCAN_DIV=4): assert rst mid-cycle -> seg=7F, an=FF, dp=1, scan_idx=0 with no clk edge. Release -> after 1 clk, an=FE, seg=40 (digit 0 value 0).
- Write/scan: write idx0..7 = 0..7, digit_en=FF, SCAN_DIV=4 -> scan_idx advances every 4 clks. an walks FE,FD,…,7F and seg tracks 40,79,24,30,19,12,02,78. Each step lags scan_idx by 1 clk.
- frame_tick: run 3 full frames with SCAN_DIV=4 -> exactly 3 one-cycle pulses, spaced 32 clks apart, each coinciding with scan_idx 7->0.
- Masking and dp: digit_en=8'b1111_1011, dp_in=8'h04 -> while scan_idx=2, an=FF, seg=7F, dp=1. Set digit_en=FF -> dp=0 on digit 2.
- Live write: while scan_idx=5 is displayed, write idx5=A -> seg changes 12->08 two edges after the write. No anode change occurs.
- Simultaneous write and advance, SCAN_DIV=1: write idx1=F on the edge where scan_idx goes 0->1 -> the next output shows seg=0E, an=FD.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Write bus into the seven-segment scan driver's digit buffer.
// The upstream register board drives it; the scan driver samples it on clk.
interface seg7_scan_driver_if;
    logic       wr_en;
    logic [2:0] wr_idx;
    logic [3:0] wr_data;

    modport master (output wr_en, output wr_idx, output wr_data);
    modport slave  (input  wr_en, input  wr_idx, input  wr_data);
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a common-anode 8-digit seven-segment display.
// Holds an 8x4 nibble buffer and shows one digit per SCAN_DIV clocks.
module seg7_scan_driver #(
    parameter int SCAN_DIV = 100000,
    parameter int DIV_W    = 17
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_driver_if.slave   wr_bus,
    input  logic [7:0]          digit_en,
    input  logic [7:0]          dp_in,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [7:0]          an,
    output logic [2:0]          scan_idx,
    output logic                frame_tick
);

    localparam logic [DIV_W-1:0] PRESC_TERM = DIV_W'(SCAN_DIV - 1);

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'h0: pattern = 7'h40;
            4'h1: pattern = 7'h79;
            4'h2: pattern = 7'h24;
            4'h3: pattern = 7'h30;
            4'h4: pattern = 7'h19;
            4'h5: pattern = 7'h12;
            4'h6: pattern = 7'h02;
            4'h7: pattern = 7'h78;
            4'h8: pattern = 7'h00;
            4'h9: pattern = 7'h10;
            4'hA: pattern = 7'h08;
            4'hB: pattern = 7'h03;
            4'hC: pattern = 7'h46;
            4'hD: pattern = 7'h21;
            4'hE: pattern = 7'h06;
            default: pattern = 7'h0E;
        endcase
        return pattern;
    endfunction

    logic [31:0]      digits_flat;
    logic [DIV_W-1:0] presc_reg, presc_next;
    logic [2:0]       scan_idx_reg, scan_idx_next;
    logic             frame_tick_reg, frame_tick_next;
    logic [6:0]       seg_reg, seg_next;
    logic             dp_reg, dp_next;
    logic [7:0]       an_reg, an_next;
    logic             scan_adv;
    logic [3:0]       cur_digit;
    logic             cur_en;

    // One nibble register per digit, flattened so the scan mux can index it.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            logic [3:0] val_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    val_reg <= 4'h0;
                end else if (wr_bus.wr_en && (wr_bus.wr_idx == 3'(gi))) begin
                    val_reg <= wr_bus.wr_data;
                end
            end
            assign digits_flat[gi*4 +: 4] = val_reg;
        end
    endgenerate

    // The >= compare keeps the prescaler inside 0..SCAN_DIV-1 even from a corrupted value.
    always_comb begin
        scan_adv        = (presc_reg >= PRESC_TERM);
        presc_next      = scan_adv ? '0 : presc_reg + 1'b1;
        scan_idx_next   = scan_adv ? scan_idx_reg + 3'd1 : scan_idx_reg;
        frame_tick_next = scan_adv && (scan_idx_reg == 3'd7);
    end

    always_comb begin
        cur_digit = digits_flat[{scan_idx_reg, 2'b00} +: 4];
        cur_en    = digit_en[scan_idx_reg];
        seg_next  = cur_en ? hex_to_seg(cur_digit) : 7'h7F;
        dp_next   = cur_en ? ~dp_in[scan_idx_reg] : 1'b1;
    end

    generate
        for (gi = 0; gi < 8; gi++) begin : g_anode
            assign an_next[gi] = ~(cur_en && (scan_idx_reg == 3'(gi)));
        end
    endgenerate

    // Output stage loads from the current scan position, so pins lag scan_idx by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg      <= '0;
            scan_idx_reg   <= 3'd0;
            frame_tick_reg <= 1'b0;
            seg_reg        <= 7'h7F;
            dp_reg         <= 1'b1;
            an_reg         <= 8'hFF;
        end else begin
            presc_reg      <= presc_next;
            scan_idx_reg   <= scan_idx_next;
            frame_tick_reg <= frame_tick_next;
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
            an_reg         <= an_next;
        end
    end

    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign an         = an_reg;
    assign scan_idx   = scan_idx_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: two drivers (SCAN_DIV=4 and SCAN_DIV=1) checked every clock
// against a behavioural display model, plus directed reset/write/frame checks.
module tb_seg7_scan_driver;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [7:0] an;
        logic [2:0] scan;
        logic       tick;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] digit_en = 8'hFF;
    logic [7:0] dp_in = 8'h00;

    logic [6:0] seg0, seg1;
    logic       dp0, dp1;
    logic [7:0] an0, an1;
    logic [2:0] scan0, scan1;
    logic       tick0, tick1;

    seg7_scan_driver_if wif0 ();
    seg7_scan_driver_if wif1 ();

    seg7_scan_driver #(.SCAN_DIV(4), .DIV_W(17)) dut0 (
        .clk(clk), .rst(rst), .wr_bus(wif0.slave),
        .digit_en(digit_en), .dp_in(dp_in),
        .seg(seg0), .dp(dp0), .an(an0), .scan_idx(scan0), .frame_tick(tick0)
    );

    seg7_scan_driver #(.SCAN_DIV(1), .DIV_W(17)) dut1 (
        .clk(clk), .rst(rst), .wr_bus(wif1.slave),
        .digit_en(digit_en), .dp_in(dp_in),
        .seg(seg1), .dp(dp1), .an(an1), .scan_idx(scan1), .frame_tick(tick1)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int         div_tab [2] = '{4, 1};

    int         m_presc [2];
    logic [2:0] m_scan  [2];
    logic [3:0] m_buf   [2][8];
    exp_t       q0 [$];
    exp_t       q1 [$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_tick_cyc = -1;
    int tick_count = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_presc[i] = 0;
            m_scan[i]  = 3'd0;
            for (int d = 0; d < 8; d++) m_buf[i][d] = 4'h0;
        end
        last_tick_cyc = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_seg0"},  32'(seg0),  32'h7F);
        check_val({tag, "_an0"},   32'(an0),   32'hFF);
        check_val({tag, "_dp0"},   32'(dp0),   32'h1);
        check_val({tag, "_scan0"}, 32'(scan0), 32'h0);
        check_val({tag, "_tick0"}, 32'(tick0), 32'h0);
        check_val({tag, "_seg1"},  32'(seg1),  32'h7F);
        check_val({tag, "_an1"},   32'(an1),   32'hFF);
        check_val({tag, "_scan1"}, 32'(scan1), 32'h0);
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        logic       we   [2];
        logic [2:0] widx [2];
        logic [3:0] wdat [2];
        exp_t e0, e1;
        we[0] = wif0.wr_en; widx[0] = wif0.wr_idx; wdat[0] = wif0.wr_data;
        we[1] = wif1.wr_en; widx[1] = wif1.wr_idx; wdat[1] = wif1.wr_data;
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            logic en;
            logic adv;
            en     = digit_en[m_scan[i]];
            e.seg  = en ? hex_tab[m_buf[i][m_scan[i]]] : 7'h7F;
            e.dp   = en ? ~dp_in[m_scan[i]] : 1'b1;
            e.an   = en ? ~(8'd1 << m_scan[i]) : 8'hFF;
            adv    = (m_presc[i] == div_tab[i] - 1);
            e.tick = adv && (m_scan[i] == 3'd7);
            m_presc[i] = adv ? 0 : m_presc[i] + 1;
            if (adv) m_scan[i] = 3'(m_scan[i] + 3'd1);
            e.scan = m_scan[i];
            if (we[i]) m_buf[i][widx[i]] = wdat[i];
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        check_val("sb0_seg",  32'(seg0),  32'(e0.seg));
        check_val("sb0_dp",   32'(dp0),   32'(e0.dp));
        check_val("sb0_an",   32'(an0),   32'(e0.an));
        check_val("sb0_scan", 32'(scan0), 32'(e0.scan));
        check_val("sb0_tick", 32'(tick0), 32'(e0.tick));
        check_val("sb1_seg",  32'(seg1),  32'(e1.seg));
        check_val("sb1_an",   32'(an1),   32'(e1.an));
        check_val("sb1_scan", 32'(scan1), 32'(e1.scan));
        check_val("sb1_tick", 32'(tick1), 32'(e1.tick));
        if (tick0) begin
            if (last_tick_cyc >= 0) check_val("tick_gap", 32'(cyc - last_tick_cyc), 32'd32);
            last_tick_cyc = cyc;
            tick_count++;
        end
        @(negedge clk);
    endtask

    task automatic do_write(input int which, input logic [2:0] idx, input logic [3:0] data);
        $display("wr dut%0d idx=%0d data=%h cycle=%0d", which, idx, data, cyc);
        if (which == 0) begin
            wif0.wr_en = 1'b1; wif0.wr_idx = idx; wif0.wr_data = data;
        end else begin
            wif1.wr_en = 1'b1; wif1.wr_idx = idx; wif1.wr_data = data;
        end
        tick();
        wif0.wr_en = 1'b0;
        wif1.wr_en = 1'b0;
    endtask

    initial begin
        bit found;
        wif0.wr_en = 1'b0; wif0.wr_idx = 3'd0; wif0.wr_data = 4'h0;
        wif1.wr_en = 1'b0; wif1.wr_idx = 3'd0; wif1.wr_data = 4'h0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        // First load after release shows digit 0 holding 0.
        tick();
        check_val("release_an",  32'(an0),  32'hFE);
        check_val("release_seg", 32'(seg0), 32'h40);

        for (int k = 0; k < 8; k++) do_write(0, 3'(k), 4'(k));
        repeat (40) tick();

        tick_count = 0;
        repeat (96) tick();
        check_val("tick_count", 32'(tick_count), 32'd3);

        // Asynchronous reset between clock edges; buffer contents are lost.
        #2 rst = 1'b1;
        #1 check_reset_outputs("async");
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        repeat (40) tick();

        for (int k = 0; k < 8; k++) do_write(0, 3'(k), 4'(k));
        digit_en = 8'b1111_1011;
        dp_in    = 8'h04;
        repeat (34) tick();
        digit_en = 8'hFF;
        repeat (34) tick();

        // Live write while digit 5 is on the pins.
        found = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            if (m_scan[0] == 3'd5 && m_presc[0] == 0) found = 1'b1;
            else tick();
        end
        check_val("live_wait", 32'(found), 32'd1);
        do_write(0, 3'd5, 4'hA);
        check_val("live_seg_old", 32'(seg0), 32'h12);
        tick();
        check_val("live_seg_new", 32'(seg0), 32'h08);
        check_val("live_an",      32'(an0),  32'hDF);
        dp_in = 8'h00;
        repeat (8) tick();

        // Write lands on the same edge that moves the SCAN_DIV=1 driver from 0 to 1.
        found = 1'b0;
        for (int k = 0; k < 16 && !found; k++) begin
            if (m_scan[1] == 3'd0) found = 1'b1;
            else tick();
        end
        check_val("simul_wait", 32'(found), 32'd1);
        do_write(1, 3'd1, 4'hF);
        check_val("simul_scan", 32'(scan1), 32'd1);
        tick();
        check_val("simul_seg", 32'(seg1), 32'h0E);
        check_val("simul_an",  32'(an1),  32'hFD);
        repeat (16) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
